// File: rtl/tlb_ctrl.sv
// TLB controller: owns the entry array, shares one combinational lookup
// datapath between instruction fetch, data access and CP0 TLB operations,
// and maintains the Random/Wired replacement registers.

package tlb_pkg;

  typedef struct packed {
    logic [18:0] vpn2;
    logic [7:0]  asid;
    logic        g;
    logic [19:0] pfn0;
    logic [2:0]  c0;
    logic        d0;
    logic        v0;
    logic [19:0] pfn1;
    logic [2:0]  c1;
    logic        d1;
    logic        v1;
  } tlb_entry_t;

  typedef struct packed {
    logic        miss;
    logic [7:0]  which;
    logic [31:0] phy_addr;
    logic        dirty;
    logic        valid;
    logic [2:0]  cache_flag;
  } tlb_result_t;

endpackage

module tlb_ctrl
  import tlb_pkg::*;
#(
  parameter int unsigned N_ENTRIES = 16,
  parameter int unsigned IDX_W     = $clog2(N_ENTRIES)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cur_asid,
  input  logic              inst_req,
  input  logic [31:0]       inst_vaddr,
  output logic              inst_gnt,
  output logic              inst_rvalid,
  output tlb_result_t       inst_result,
  input  logic              data_req,
  input  logic [31:0]       data_vaddr,
  output logic              data_gnt,
  output logic              data_rvalid,
  output tlb_result_t       data_result,
  input  logic              op_valid,
  input  logic [1:0]        op_code,
  input  logic [IDX_W-1:0]  op_index,
  input  logic [18:0]       op_vpn2,
  input  logic [7:0]        op_asid,
  input  tlb_entry_t        op_wentry,
  output logic              op_ready,
  output logic              op_done,
  output tlb_entry_t        op_rentry,
  output logic              probe_miss,
  output logic [IDX_W-1:0]  probe_index,
  input  logic              wired_we,
  input  logic [IDX_W-1:0]  wired_wdata,
  output logic [IDX_W-1:0]  random_o
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } state_t;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'd0,
    OP_TLBR  = 2'd1,
    OP_TLBWI = 2'd2,
    OP_TLBWR = 2'd3
  } op_t;

  localparam logic [IDX_W-1:0] IDX_MAX = IDX_W'(N_ENTRIES - 1);

  tlb_entry_t        entries [N_ENTRIES];
  state_t            state;
  op_t               op_code_q;
  logic [IDX_W-1:0]  op_index_q;
  logic [18:0]       op_vpn2_q;
  logic [7:0]        op_asid_q;
  tlb_entry_t        op_wentry_q;

  logic [IDX_W-1:0]  random_q;
  logic [IDX_W-1:0]  wired_q;
  logic              rr_data;
  logic              lookup_free;

  logic [31:0]       cmp_vaddr;
  logic [7:0]        cmp_asid;
  logic              cmp_hit;
  logic [IDX_W-1:0]  cmp_idx;
  tlb_entry_t        hit_entry;
  tlb_result_t       cmp_result;

  assign random_o = random_q;

  // Lookup grants only in IDLE with no CP0 op pending; contested cycles go to rr_data's choice
  always_comb begin
    lookup_free = (state == ST_IDLE) && !op_valid;
    data_gnt    = lookup_free && data_req && (!inst_req || rr_data);
    inst_gnt    = lookup_free && inst_req && (!data_req || !rr_data);
    op_ready    = (state == ST_IDLE) && op_valid;
  end

  // Comparator input select: probe in EXEC, otherwise whichever side is granted
  always_comb begin
    if (state == ST_EXEC) begin
      cmp_vaddr = {op_vpn2_q, 13'b0};
      cmp_asid  = op_asid_q;
    end else if (data_gnt) begin
      cmp_vaddr = data_vaddr;
      cmp_asid  = cur_asid;
    end else begin
      cmp_vaddr = inst_vaddr;
      cmp_asid  = cur_asid;
    end
  end

  // Shared associative match: lowest matching index wins
  always_comb begin
    cmp_hit = 1'b0;
    cmp_idx = '0;
    for (int unsigned i = 0; i < N_ENTRIES; i++) begin
      if (!cmp_hit && (entries[i].vpn2 == cmp_vaddr[31:13]) &&
          (entries[i].g || (entries[i].asid == cmp_asid))) begin
        cmp_hit = 1'b1;
        cmp_idx = IDX_W'(i);
      end
    end
  end

  // Page-half select and physical address formation for the matched entry
  always_comb begin
    hit_entry       = entries[cmp_idx];
    cmp_result      = '0;
    cmp_result.miss = !cmp_hit;
    if (cmp_hit) begin
      cmp_result.which = 8'(cmp_idx);
      if (cmp_vaddr[12]) begin
        cmp_result.phy_addr   = {hit_entry.pfn1, cmp_vaddr[11:0]};
        cmp_result.dirty      = hit_entry.d1;
        cmp_result.valid      = hit_entry.v1;
        cmp_result.cache_flag = hit_entry.c1;
      end else begin
        cmp_result.phy_addr   = {hit_entry.pfn0, cmp_vaddr[11:0]};
        cmp_result.dirty      = hit_entry.d0;
        cmp_result.valid      = hit_entry.v0;
        cmp_result.cache_flag = hit_entry.c0;
      end
    end
  end

  // Registered lookup results: rvalid mirrors the previous cycle's grant
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      inst_rvalid <= 1'b0;
      data_rvalid <= 1'b0;
      inst_result <= '0;
      data_result <= '0;
    end else begin
      inst_rvalid <= inst_gnt;
      data_rvalid <= data_gnt;
      if (inst_gnt) inst_result <= cmp_result;
      if (data_gnt) data_result <= cmp_result;
    end
  end

  // Round-robin pointer: after a contested grant the loser is favoured
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_data <= 1'b1;
    end else if (lookup_free && inst_req && data_req) begin
      rr_data <= !data_gnt;
    end
  end

  // Random counts down to Wired and wraps; a Wired write restarts it at the top
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random_q <= IDX_MAX;
      wired_q  <= '0;
    end else if (wired_we) begin
      wired_q  <= wired_wdata;
      random_q <= IDX_MAX;
    end else if ((wired_q >= IDX_MAX) || (random_q <= wired_q)) begin
      random_q <= IDX_MAX;
    end else begin
      random_q <= random_q - IDX_W'(1);
    end
  end

  // CP0 operation FSM: accept in IDLE, execute in EXEC, report in DONE
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      op_code_q   <= OP_TLBP;
      op_index_q  <= '0;
      op_vpn2_q   <= '0;
      op_asid_q   <= '0;
      op_wentry_q <= '0;
      op_done     <= 1'b0;
      op_rentry   <= '0;
      probe_miss  <= 1'b1;
      probe_index <= '0;
      for (int unsigned i = 0; i < N_ENTRIES; i++) begin
        entries[i] <= '0;
      end
    end else begin
      op_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (op_valid) begin
            op_code_q   <= op_t'(op_code);
            op_index_q  <= op_index;
            op_vpn2_q   <= op_vpn2;
            op_asid_q   <= op_asid;
            op_wentry_q <= op_wentry;
            state       <= ST_EXEC;
          end
        end
        ST_EXEC: begin
          case (op_code_q)
            OP_TLBP: begin
              probe_miss  <= !cmp_hit;
              probe_index <= cmp_idx;
            end
            OP_TLBR:  op_rentry <= entries[op_index_q];
            OP_TLBWI: entries[op_index_q] <= op_wentry_q;
            OP_TLBWR: entries[random_q] <= op_wentry_q;
            default: ;
          endcase
          op_done <= 1'b1;
          state   <= ST_DONE;
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tlb_ctrl.sv
// Testbench for tlb_ctrl: directed scenarios followed by randomized traffic,
// all checked against a cycle-level behavioural model of the TLB.

module tb_tlb_ctrl;
  import tlb_pkg::*;

  localparam int unsigned N = 16;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  cur_asid;
  logic        inst_req, data_req;
  logic [31:0] inst_vaddr, data_vaddr;
  logic        inst_gnt, data_gnt, inst_rvalid, data_rvalid;
  tlb_result_t inst_result, data_result;
  logic        op_valid;
  logic [1:0]  op_code;
  logic [3:0]  op_index;
  logic [18:0] op_vpn2;
  logic [7:0]  op_asid;
  tlb_entry_t  op_wentry;
  logic        op_ready, op_done;
  tlb_entry_t  op_rentry;
  logic        probe_miss;
  logic [3:0]  probe_index;
  logic        wired_we;
  logic [3:0]  wired_wdata;
  logic [3:0]  random_o;

  tlb_ctrl #(.N_ENTRIES(16)) dut (
    .clk(clk), .rst_n(rst_n), .cur_asid(cur_asid),
    .inst_req(inst_req), .inst_vaddr(inst_vaddr), .inst_gnt(inst_gnt),
    .inst_rvalid(inst_rvalid), .inst_result(inst_result),
    .data_req(data_req), .data_vaddr(data_vaddr), .data_gnt(data_gnt),
    .data_rvalid(data_rvalid), .data_result(data_result),
    .op_valid(op_valid), .op_code(op_code), .op_index(op_index),
    .op_vpn2(op_vpn2), .op_asid(op_asid), .op_wentry(op_wentry),
    .op_ready(op_ready), .op_done(op_done), .op_rentry(op_rentry),
    .probe_miss(probe_miss), .probe_index(probe_index),
    .wired_we(wired_we), .wired_wdata(wired_wdata), .random_o(random_o)
  );

  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;

  // Reference model state
  tlb_entry_t  m_ent [N];
  int unsigned m_random, m_wired, m_busy;
  bit          m_fav_data;
  logic [1:0]  m_code;
  logic [3:0]  m_index;
  logic [18:0] m_vpn2;
  logic [7:0]  m_asid;
  tlb_entry_t  m_went;
  bit          last_ig, last_dg;

  task automatic check_val(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic tlb_result_t ref_lookup(input logic [31:0] va, input logic [7:0] asid);
    tlb_result_t r;
    bit found;
    r = '0;
    r.miss = 1'b1;
    found = 1'b0;
    for (int i = 0; i < int'(N); i++) begin
      if (!found && m_ent[i].vpn2 == va[31:13] && (m_ent[i].g || m_ent[i].asid == asid)) begin
        found = 1'b1;
        r.miss = 1'b0;
        r.which = 8'(i);
        if (va[12]) begin
          r.phy_addr = 32'(m_ent[i].pfn1) * 32'd4096 + (va % 32'd4096);
          r.dirty = m_ent[i].d1; r.valid = m_ent[i].v1; r.cache_flag = m_ent[i].c1;
        end else begin
          r.phy_addr = 32'(m_ent[i].pfn0) * 32'd4096 + (va % 32'd4096);
          r.dirty = m_ent[i].d0; r.valid = m_ent[i].v0; r.cache_flag = m_ent[i].c0;
        end
      end
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < int'(N); i++) m_ent[i] = '0;
    m_random = N - 1;
    m_wired = 0;
    m_busy = 0;
    m_fav_data = 1'b1;
  endtask

  // One clock cycle: inputs already driven at posedge+1; returns at next posedge+1
  task automatic step();
    bit free, eg_i, eg_d, n_done;
    tlb_result_t n_ires, n_dres, n_probe;
    tlb_entry_t  n_rentry;
    logic [1:0]  done_code;
    n_done = 1'b0; done_code = 2'd0; n_probe = '0; n_rentry = '0;
    #3;
    free = (m_busy == 0) && !op_valid;
    eg_d = free && data_req && (!inst_req || m_fav_data);
    eg_i = free && inst_req && (!data_req || !m_fav_data);
    check_val("inst_gnt", 128'(inst_gnt), 128'(eg_i));
    check_val("data_gnt", 128'(data_gnt), 128'(eg_d));
    check_val("op_ready", 128'(op_ready), 128'((m_busy == 0) && op_valid));
    last_ig = eg_i;
    last_dg = eg_d;
    n_ires = ref_lookup(inst_vaddr, cur_asid);
    n_dres = ref_lookup(data_vaddr, cur_asid);
    if (free && inst_req && data_req) m_fav_data = !m_fav_data;
    if (m_busy == 2) begin
      n_done = 1'b1;
      done_code = m_code;
      case (m_code)
        2'd0: n_probe = ref_lookup({m_vpn2, 13'b0}, m_asid);
        2'd1: n_rentry = m_ent[m_index];
        2'd2: m_ent[m_index] = m_went;
        default: m_ent[m_random] = m_went;
      endcase
      m_busy = 1;
    end else if (m_busy == 1) begin
      m_busy = 0;
    end else if (op_valid) begin
      m_code = op_code; m_index = op_index; m_vpn2 = op_vpn2;
      m_asid = op_asid; m_went = op_wentry;
      m_busy = 2;
    end
    if (wired_we) begin
      m_wired = 32'(wired_wdata);
      m_random = N - 1;
    end else if (m_wired >= N - 1 || m_random == m_wired) begin
      m_random = N - 1;
    end else begin
      m_random = m_random - 1;
    end
    @(posedge clk);
    #1;
    check_val("inst_rvalid", 128'(inst_rvalid), 128'(eg_i));
    check_val("data_rvalid", 128'(data_rvalid), 128'(eg_d));
    if (eg_i) check_val("inst_result", 128'(inst_result), 128'(n_ires));
    if (eg_d) check_val("data_result", 128'(data_result), 128'(n_dres));
    check_val("op_done", 128'(op_done), 128'(n_done));
    if (n_done && done_code == 2'd0) begin
      check_val("probe_miss", 128'(probe_miss), 128'(n_probe.miss));
      if (!n_probe.miss) check_val("probe_index", 128'(probe_index), 128'(n_probe.which));
    end
    if (n_done && done_code == 2'd1) check_val("op_rentry", 128'(op_rentry), 128'(n_rentry));
    check_val("random_o", 128'(random_o), 128'(m_random));
  endtask

  task automatic do_op(input logic [1:0] code, input logic [3:0] idx, input logic [18:0] vpn2,
                       input logic [7:0] asid, input tlb_entry_t we);
    op_valid = 1'b1; op_code = code; op_index = idx; op_vpn2 = vpn2;
    op_asid = asid; op_wentry = we;
    step();
    op_valid = 1'b0;
    step();
    step();
  endtask

  function automatic tlb_entry_t rand_entry();
    tlb_entry_t e;
    e.vpn2 = 19'h10 + 19'($urandom_range(0, 3));
    e.asid = ($urandom_range(0, 1) == 0) ? 8'd5 : 8'd6;
    e.g    = 1'($urandom_range(0, 1));
    e.pfn0 = 20'($urandom); e.c0 = 3'($urandom); e.d0 = 1'($urandom); e.v0 = 1'($urandom);
    e.pfn1 = 20'($urandom); e.c1 = 3'($urandom); e.d1 = 1'($urandom); e.v1 = 1'($urandom);
    return e;
  endfunction

  function automatic logic [31:0] rand_va();
    logic [18:0] vp;
    vp = 19'h10 + 19'($urandom_range(0, 4));
    return {vp, 13'($urandom)};
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tlb_entry_t e;
    logic [3:0] wr_idx;
    rst_n = 1'b0; cur_asid = 8'd5;
    inst_req = 1'b0; data_req = 1'b0; inst_vaddr = '0; data_vaddr = '0;
    op_valid = 1'b0; op_code = '0; op_index = '0; op_vpn2 = '0; op_asid = '0; op_wentry = '0;
    wired_we = 1'b0; wired_wdata = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_val("rst_inst_rvalid", 128'(inst_rvalid), 128'(0));
    check_val("rst_op_done", 128'(op_done), 128'(0));
    check_val("rst_probe_miss", 128'(probe_miss), 128'(1));
    check_val("rst_probe_index", 128'(probe_index), 128'(0));
    check_val("rst_random", 128'(random_o), 128'(15));
    check_val("rst_rentry", 128'(op_rentry), 128'(0));
    check_val("rst_inst_result", 128'(inst_result), 128'(0));
    rst_n = 1'b1;
    step();

    // TLBWI entry 3, then an instruction lookup hitting its even page
    e = '0; e.vpn2 = 19'h10; e.asid = 8'd5; e.pfn0 = 20'h12345; e.v0 = 1'b1;
    do_op(2'd2, 4'd3, '0, '0, e);
    inst_req = 1'b1; inst_vaddr = 32'h0002_0ABC;
    step();
    inst_req = 1'b0;
    check_val("t1_gnt", 128'(last_ig), 128'(1));
    check_val("t1_miss", 128'(inst_result.miss), 128'(0));
    check_val("t1_which", 128'(inst_result.which), 128'(3));
    check_val("t1_phy", 128'(inst_result.phy_addr), 128'(32'h1234_5ABC));
    check_val("t1_valid", 128'(inst_result.valid), 128'(1));

    // TLBP together with a pending instruction lookup: op wins for three cycles
    inst_req = 1'b1;
    op_valid = 1'b1; op_code = 2'd0; op_vpn2 = 19'h10; op_asid = 8'd5;
    step();
    op_valid = 1'b0;
    check_val("tp_ready_gnt", 128'(last_ig), 128'(0));
    step();
    check_val("tp_exec_gnt", 128'(last_ig), 128'(0));
    step();
    check_val("tp_done_gnt", 128'(last_ig), 128'(0));
    check_val("tp_probe_miss", 128'(probe_miss), 128'(0));
    check_val("tp_probe_index", 128'(probe_index), 128'(3));
    step();
    check_val("tp_after_gnt", 128'(last_ig), 128'(1));
    inst_req = 1'b0;

    // ASID mismatch misses, global bit makes it hit
    cur_asid = 8'd6; data_req = 1'b1; data_vaddr = 32'h0002_0ABC;
    step();
    data_req = 1'b0;
    check_val("asid_miss", 128'(data_result.miss), 128'(1));
    e.g = 1'b1;
    do_op(2'd2, 4'd3, '0, '0, e);
    data_req = 1'b1;
    step();
    data_req = 1'b0;
    check_val("g_hit_miss", 128'(data_result.miss), 128'(0));
    check_val("g_hit_which", 128'(data_result.which), 128'(3));

    // Entries 2 and 7 both match an odd page: lowest index wins
    e = '0; e.vpn2 = 19'h10; e.g = 1'b1; e.pfn1 = 20'hAAAAA; e.v1 = 1'b1; e.d1 = 1'b1;
    do_op(2'd2, 4'd2, '0, '0, e);
    e.pfn1 = 20'hBBBBB;
    do_op(2'd2, 4'd7, '0, '0, e);
    data_req = 1'b1; data_vaddr = 32'h0002_1000;
    step();
    data_req = 1'b0;
    check_val("multi_which", 128'(data_result.which), 128'(2));
    check_val("multi_phy", 128'(data_result.phy_addr), 128'(32'hAAAA_A000));

    // Both requesters held: grants alternate starting with data
    inst_req = 1'b1; data_req = 1'b1; inst_vaddr = 32'h0002_0123;
    for (int k = 0; k < 4; k++) begin
      step();
      check_val("rr_data_gnt", 128'(last_dg), 128'((k % 2) == 0));
    end
    inst_req = 1'b0; data_req = 1'b0;

    // Wired = 4: Random sweeps 15..4 and wraps (checked every cycle by step)
    cur_asid = 8'd5;
    wired_we = 1'b1; wired_wdata = 4'd4;
    step();
    wired_we = 1'b0;
    repeat (27) step();

    // TLBWR writes the index shown on random_o during EXEC
    e = rand_entry();
    op_valid = 1'b1; op_code = 2'd3; op_wentry = e;
    step();
    op_valid = 1'b0;
    wr_idx = random_o;
    step();
    step();
    do_op(2'd1, wr_idx, '0, '0, '0);
    check_val("tlbwr_entry", 128'(op_rentry), 128'(e));

    // Reset asserted during EXEC: no write, no op_done
    e = rand_entry();
    op_valid = 1'b1; op_code = 2'd2; op_index = 4'd5; op_wentry = e;
    step();
    op_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_val("rstx_op_done", 128'(op_done), 128'(0));
    @(posedge clk);
    #1;
    check_val("rstx_op_done2", 128'(op_done), 128'(0));
    check_val("rstx_random", 128'(random_o), 128'(15));
    model_reset();
    rst_n = 1'b1;
    step();
    step();
    do_op(2'd1, 4'd5, '0, '0, '0);
    check_val("rstx_entry5", 128'(op_rentry), 128'(0));
    do_op(2'd1, 4'd3, '0, '0, '0);
    check_val("rstx_entry3", 128'(op_rentry), 128'(0));

    // Randomized traffic
    for (int c = 0; c < 400; c++) begin
      if (!inst_req || last_ig) begin
        inst_req = 1'($urandom_range(0, 1)); inst_vaddr = rand_va();
      end else if ($urandom_range(0, 15) == 0) begin
        inst_req = 1'b0;
      end
      if (!data_req || last_dg) begin
        data_req = 1'($urandom_range(0, 1)); data_vaddr = rand_va();
      end else if ($urandom_range(0, 15) == 0) begin
        data_req = 1'b0;
      end
      op_valid = (m_busy == 0) && ($urandom_range(0, 5) == 0);
      op_code = 2'($urandom); op_index = 4'($urandom);
      op_vpn2 = 19'h10 + 19'($urandom_range(0, 3));
      op_asid = ($urandom_range(0, 1) == 0) ? 8'd5 : 8'd6;
      op_wentry = rand_entry();
      wired_we = ($urandom_range(0, 31) == 0);
      wired_wdata = 4'($urandom);
      if ($urandom_range(0, 15) == 0) cur_asid = (cur_asid == 8'd5) ? 8'd6 : 8'd5;
      step();
    end
    inst_req = 1'b0; data_req = 1'b0; op_valid = 1'b0; wired_we = 1'b0;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/tlb_ctrl.md
Name: tlb_ctrl

Overview:
Owns the TLB entry array and arbitrates one shared combinational lookup datapath between instruction-fetch, data-access and CP0 TLB-instruction requesters. Executes TLBP, TLBR, TLBWI and TLBWR, and maintains the Random and Wired registers. Sits in the MMU between the IF/MEM pipeline stages and CP0.

Parameters:
N_ENTRIES, 16, number of TLB entries; power of two.
IDX_W, $clog2(N_ENTRIES), index width.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
cur_asid  in  8  current ASID (CP0 EntryHi.ASID)
inst_req  in  1  instruction translation request
inst_vaddr  in  32  instruction virtual address
inst_gnt  out  1  combinational grant; request consumed this cycle
inst_rvalid  out  1  result valid; one cycle after grant
inst_result  out  tlb_result_t  miss/which/phy_addr/dirty/valid/cache_flag
data_req, data_vaddr, data_gnt, data_rvalid, data_result  same as inst_* for the data side
op_valid  in  1  CP0 TLB operation request
op_code  in  2  0=TLBP, 1=TLBR, 2=TLBWI, 3=TLBWR
op_index  in  IDX_W  CP0 Index, for TLBR/TLBWI
op_vpn2  in  19  EntryHi.VPN2, for TLBP
op_asid  in  8  EntryHi.ASID, for TLBP
op_wentry  in  tlb_entry_t  entry to write, for TLBWI/TLBWR
op_ready  out  1  operation accepted this cycle
op_done  out  1  one-cycle pulse when results are valid
op_rentry  out  tlb_entry_t  TLBR data; held until next op_done
probe_miss  out  1  TLBP result: no match
probe_index  out  IDX_W  TLBP lowest matching index
wired_we  in  1  CP0 write to Wired
wired_wdata  in  IDX_W  new Wired value
random_o  out  IDX_W  current Random value

Behaviour:
- Reset: all entries zero; Random = N_ENTRIES-1; Wired = 0; all gnt/rvalid/op_ready/op_done = 0; op_rentry = 0; probe_miss = 1; probe_index = 0; results = 0; FSM = IDLE; round-robin pointer favours data. Reset mid-operation aborts the operation; no partial entry write.
- Lookup semantics:
  - Entry i matches when vpn2 == vaddr[31:13] and (asid equal or G set).
  - Lowest matching index wins.
  - miss = no match.
  - vaddr[12] selects the odd half (pfn1/d1/v1/c1), otherwise the even half.
  - phy_addr[11:0] = vaddr[11:0].
- Result path: result registered; rvalid asserts exactly one cycle after gnt and is otherwise 0. Back-to-back grants give back-to-back results.
- FSM states:
  - IDLE: if op_valid, assert op_ready, latch op fields, go to EXEC. Otherwise arbitrate lookups.
  - EXEC: perform the operation, go to DONE.
  - DONE: pulse op_done, go to IDLE.
- Lookup grants are issued only in IDLE and only when op_valid=0. CP0 operations have absolute priority. No grants in EXEC/DONE.
- Arbitration, both lookup requesters pending: round-robin; the loser of the last contested cycle wins next. A single requester is granted immediately.
- TLBP (EXEC): drives the shared comparator with {op_vpn2, 13'b0} and op_asid. Registers probe_miss/probe_index, valid with op_done.
- TLBR (EXEC): op_rentry <= entries[op_index].
- TLBWI (EXEC): entries[op_index] <= op_wentry.
- TLBWR (EXEC): entries[Random] <= op_wentry, using Random as sampled in that EXEC cycle.
- Lookups granted after op_done observe the written entry.
- Random: decrements every cycle.
  - If Random == Wired, it wraps to N_ENTRIES-1 next cycle.
  - Wired >= N_ENTRIES-1 holds Random at N_ENTRIES-1.
  - wired_we: Wired <= wired_wdata and Random <= N_ENTRIES-1, overriding the decrement in that cycle.
- Simultaneous events:
  - op_valid with a lookup request: op accepted, lookup not granted; the requester must hold req.
  - wired_we during TLBWR EXEC: the write uses the pre-update Random.
- Requesters hold req and vaddr until gnt. Deasserting req before gnt is legal and produces no result.

Test Plan:
- Reset, then TLBWI index 3 with vpn2=0x00010, asid=5, G=0, pfn0=0x12345, v0=1; inst_req vaddr 0x00020ABC with cur_asid=5 -> gnt same cycle; next cycle rvalid, miss=0, which=3, phy_addr=0x12345ABC, valid=1.
- Same entry, data_req with cur_asid=6 -> miss=1. Set G=1 through TLBWI, repeat -> hit, which=3.
- Entries 2 and 7 both match vaddr 0x00021000 (odd page) -> which=2, phy_addr from pfn1 of entry 2.
- inst_req and data_req held high for 4 cycles -> grants alternate D,I,D,I; each rvalid one cycle after its grant.
- op_valid TLBP (vpn2=0x00010, asid=5) together with inst_req -> op_ready=1, inst_gnt=0 for 3 cycles; op_done on cycle 3 with probe_miss=0, probe_index=3; inst_gnt the following cycle.
- Wired=4 after reset -> Random cycles 15..4 then wraps to 15; TLBWR writes the index shown on random_o in the EXEC cycle. Assert rst_n low during EXEC -> entries cleared, op_done never pulses.
